// File: rtl/sy_pkg.sv
// Shared SV39 MMU types (PTE and TLB refill payload) plus page-table walker constants.
package sy_pkg;

    localparam int unsigned PTE_SIZE_LOG2 = 3;
    localparam int unsigned SV39_LEVELS   = 3;
    localparam int unsigned VPN_W         = 9;
    localparam int unsigned PPN_W         = 44;
    localparam int unsigned ASID_W        = 1;

    typedef struct packed {
        logic [9:0]       reserved;
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    typedef struct packed {
        logic              valid;
        logic              is_2M;
        logic              is_1G;
        logic [26:0]       vpn;
        logic [ASID_W-1:0] asid;
        pte_t              content;
    } tlb_update_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WAIT_RVALID,
        ST_DONE,
        ST_FAULT,
        ST_FLUSH_DRAIN
    } ptw_state_e;

    // VPN slice of a virtual address for the given table level
    function automatic logic [VPN_W-1:0] vpn_at(input logic [63:0] va, input logic [1:0] lvl);
        case (lvl)
            2'd2:    return va[38:30];
            2'd1:    return va[29:21];
            default: return va[20:12];
        endcase
    endfunction

    // Physical address of the PTE indexed by vpn inside the table at ppn
    function automatic logic [PPN_W+VPN_W+PTE_SIZE_LOG2-1:0] pte_addr(input logic [PPN_W-1:0] ppn,
                                                                      input logic [VPN_W-1:0] vpn);
        return {ppn, vpn, {PTE_SIZE_LOG2{1'b0}}};
    endfunction

endpackage

// File: rtl/sy_ptw_pte_check.sv
// Combinational SV39 PTE classifier: leaf / pointer / fault for the current walk level.
module sy_ptw_pte_check
    import sy_pkg::*;
(
    input  pte_t       pte,
    input  logic [1:0] level,
    input  logic       is_store,
    output logic       is_leaf,
    output logic       is_ptr,
    output logic       fault
);

    logic invalid;
    logic misaligned;
    logic leaf_fault;
    logic unused_bits;

    assign invalid    = !pte.v || (!pte.r && pte.w) || (pte.reserved != '0);
    assign is_leaf    = !invalid && (pte.r || pte.x);
    assign is_ptr     = !invalid && !pte.r && !pte.w && !pte.x;

    // Superpage leaves must have their low PPN fields cleared
    assign misaligned = ((level == 2'd2) && (pte.ppn[17:0] != '0)) ||
                        ((level == 2'd1) && (pte.ppn[8:0]  != '0));
    assign leaf_fault = !pte.a || (is_store && !pte.d) || misaligned;

    assign fault      = invalid || (is_leaf && leaf_fault) || (is_ptr && (level == 2'd0));

    assign unused_bits = ^{pte.rsw, pte.g, pte.u, pte.ppn[43:18]};

endmodule

// File: rtl/sy_ptw_sv39.sv
// SV39 hardware page-table walker feeding TLB refills; one walk in flight.
// Optional SY_PTW_PERF_EN adds walk/fault/PTE-read counters.
module sy_ptw_sv39
    import sy_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned PADDR_W    = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [63:0]           req_vaddr_i,
    input  logic                  req_is_store_i,
    input  logic [ASID_WIDTH-1:0] req_asid_i,
    input  logic [43:0]           satp_ppn_i,
    output logic                  mem_req_o,
    output logic [PADDR_W-1:0]    mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [63:0]           mem_rdata_i,
    output tlb_update_t           update_o,
    output logic                  walking_o,
`ifdef SY_PTW_PERF_EN
    output logic [31:0]           walk_cnt_o,
    output logic [31:0]           fault_cnt_o,
    output logic [31:0]           mem_cnt_o,
`endif
    output logic                  fault_o,
    output logic [63:0]           fault_vaddr_o
);

    ptw_state_e            state;
    logic [1:0]            level;
    logic [63:0]           vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  store_q;
    logic                  ready_q;
    logic                  fault_q;
    tlb_update_t           upd_q;

    pte_t pte;
    logic pte_leaf;
    logic pte_ptr;
    logic pte_fault;
    logic canonical;

    assign pte       = pte_t'(mem_rdata_i);
    assign canonical = (req_vaddr_i[63:39] == {25{req_vaddr_i[38]}});

    sy_ptw_pte_check u_pte_check (
        .pte      (pte),
        .level    (level),
        .is_store (store_q),
        .is_leaf  (pte_leaf),
        .is_ptr   (pte_ptr),
        .fault    (pte_fault)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            level      <= 2'(SV39_LEVELS - 1);
            vaddr_q    <= '0;
            asid_q     <= '0;
            store_q    <= 1'b0;
            ready_q    <= 1'b1;
            fault_q    <= 1'b0;
            upd_q      <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            upd_q.valid <= 1'b0;
            fault_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        vaddr_q <= req_vaddr_i;
                        asid_q  <= req_asid_i;
                        store_q <= req_is_store_i;
                        level   <= 2'(SV39_LEVELS - 1);
                        ready_q <= 1'b0;
                        if (!canonical) begin
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state      <= ST_WAIT_GNT;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= PADDR_W'(pte_addr(satp_ppn_i, vpn_at(req_vaddr_i, 2'd2)));
                        end
                    end
                end
                ST_WAIT_GNT: begin
                    // A grant coinciding with flush leaves a read outstanding that must drain
                    if (flush_i) begin
                        mem_req_o <= 1'b0;
                        state     <= mem_gnt_i ? ST_FLUSH_DRAIN : ST_IDLE;
                        ready_q   <= !mem_gnt_i;
                    end else if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_WAIT_RVALID;
                    end
                end
                ST_WAIT_RVALID: begin
                    if (flush_i) begin
                        state   <= mem_rvalid_i ? ST_IDLE : ST_FLUSH_DRAIN;
                        ready_q <= mem_rvalid_i;
                    end else if (mem_rvalid_i) begin
                        if (pte_fault) begin
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else if (pte_leaf) begin
                            state         <= ST_DONE;
                            upd_q.valid   <= 1'b1;
                            upd_q.is_1G   <= (level == 2'd2);
                            upd_q.is_2M   <= (level == 2'd1);
                            upd_q.vpn     <= vaddr_q[38:12];
                            upd_q.asid    <= ASID_W'(asid_q);
                            upd_q.content <= pte;
                        end else begin
                            state      <= ST_WAIT_GNT;
                            level      <= level - 2'd1;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= PADDR_W'(pte_addr(pte.ppn, vpn_at(vaddr_q, level - 2'd1)));
                        end
                    end
                end
                ST_FLUSH_DRAIN: begin
                    if (mem_rvalid_i) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // A flush landing on the DONE/FAULT cycle cancels the pulse
    always_comb begin
        update_o       = upd_q;
        update_o.valid = upd_q.valid && !flush_i;
    end

    assign fault_o       = fault_q && !flush_i;
    assign req_ready_o   = ready_q;
    assign walking_o     = !ready_q;
    assign fault_vaddr_o = vaddr_q;

`ifdef SY_PTW_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            walk_cnt_o  <= '0;
            fault_cnt_o <= '0;
            mem_cnt_o   <= '0;
        end else begin
            if ((state == ST_IDLE) && req_valid_i) walk_cnt_o  <= walk_cnt_o + 32'd1;
            if (fault_o)                           fault_cnt_o <= fault_cnt_o + 32'd1;
            if (mem_req_o && mem_gnt_i)            mem_cnt_o   <= mem_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sy_ptw_sv39.sv
// Directed self-checking bench for the SV39 page-table walker.
module tb_sy_ptw_sv39;
    import sy_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_vaddr_i = '0;
    logic        req_is_store_i = 1'b0;
    logic [0:0]  req_asid_i = '0;
    logic [43:0] satp_ppn_i = 44'h80000;
    logic        mem_req_o;
    logic [55:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    tlb_update_t update_o;
    logic        walking_o;
    logic        fault_o;
    logic [63:0] fault_vaddr_o;
`ifdef SY_PTW_PERF_EN
    logic [31:0] walk_cnt_o, fault_cnt_o, mem_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    sy_ptw_sv39 #(.ASID_WIDTH(1), .PADDR_W(56)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_vaddr_i    (req_vaddr_i),
        .req_is_store_i (req_is_store_i),
        .req_asid_i     (req_asid_i),
        .satp_ppn_i     (satp_ppn_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .update_o       (update_o),
        .walking_o      (walking_o),
`ifdef SY_PTW_PERF_EN
        .walk_cnt_o     (walk_cnt_o),
        .fault_cnt_o    (fault_cnt_o),
        .mem_cnt_o      (mem_cnt_o),
`endif
        .fault_o        (fault_o),
        .fault_vaddr_o  (fault_vaddr_o)
    );

    int n_checks = 0;
    int n_err    = 0;
    int upd_cnt  = 0;
    int flt_cnt  = 0;
    int rd_cnt   = 0;
    logic req_seen = 1'b0;

    always @(posedge clk_i) begin
        if (update_o.valid)          upd_cnt++;
        if (fault_o)                 flt_cnt++;
        if (mem_req_o && mem_gnt_i)  rd_cnt++;
        if (mem_req_o)               req_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'b0, ppn, 2'b00, flags};
    endfunction

    task automatic start_walk(input logic [63:0] va, input logic st);
        @(negedge clk_i);
        req_valid_i    = 1'b1;
        req_vaddr_i    = va;
        req_is_store_i = st;
        req_asid_i     = 1'b1;
        @(negedge clk_i);
        req_valid_i    = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int t = 0;
        while (!mem_req_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check({tag, "_req"}, 64'(mem_req_o), 64'd1);
    endtask

    // Grant after gdly stalled cycles, return data on the following cycle
    task automatic serve(input string tag, input logic [55:0] exp_addr, input logic [63:0] data,
                         input int gdly);
        logic stable = 1'b1;
        wait_req(tag);
        for (int i = 0; i < gdly; i++) begin
            if (mem_addr_o !== exp_addr || !mem_req_o) stable = 1'b0;
            @(negedge clk_i);
        end
        check({tag, "_stable"}, 64'(stable), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr_o), 64'(exp_addr));
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
    endtask

    localparam logic [7:0] FL_ALL  = 8'hCF;
    localparam logic [7:0] FL_PTR  = 8'h01;
    localparam logic [7:0] FL_ND   = 8'h47;
    localparam logic [63:0] VA1    = 64'h0000_0000_4040_3123;
    localparam logic [63:0] VA3    = 64'h0000_0000_C000_0000;
    localparam logic [63:0] VA_NC  = 64'h0000_0080_0000_0000;

    initial begin
        int u0, f0, r0;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_ready",   64'(req_ready_o), 64'd1);
        check("rst_walking", 64'(walking_o), 64'd0);
        check("rst_memreq",  64'(mem_req_o), 64'd0);
        check("rst_fault",   64'(fault_o), 64'd0);
        check("rst_upd",     64'(update_o.valid), 64'd0);
        check("rst_fva",     fault_vaddr_o, 64'd0);

        // 4K walk through two pointers
        u0 = upd_cnt; r0 = rd_cnt;
        start_walk(VA1, 1'b0);
        check("t1_walking", 64'(walking_o), 64'd1);
        serve("t1_l2", 56'h8000_0008, mk_pte(44'h80001, FL_PTR), 0);
        serve("t1_l1", 56'h8000_1010, mk_pte(44'h80002, FL_PTR), 0);
        serve("t1_l0", 56'h8000_2018, mk_pte(44'h90000, FL_ALL), 0);
        check("t1_valid",   64'(update_o.valid), 64'd1);
        check("t1_vpn",     64'(update_o.vpn), 64'h40403);
        check("t1_1G",      64'(update_o.is_1G), 64'd0);
        check("t1_2M",      64'(update_o.is_2M), 64'd0);
        check("t1_asid",    64'(update_o.asid), 64'd1);
        check("t1_content", 64'(update_o.content), 64'h0000_0000_2400_00CF);
        @(negedge clk_i);
        check("t1_pulse",   64'(update_o.valid), 64'd0);
        check("t1_ready",   64'(req_ready_o), 64'd1);
        check("t1_count",   64'(upd_cnt - u0), 64'd1);
        check("t1_reads",   64'(rd_cnt - r0), 64'd3);

        // 1G leaf, then misaligned superpage
        u0 = upd_cnt; r0 = rd_cnt;
        start_walk(VA1, 1'b0);
        serve("t2_l2", 56'h8000_0008, mk_pte(44'h40000, FL_ALL), 0);
        check("t2_valid", 64'(update_o.valid), 64'd1);
        check("t2_1G",    64'(update_o.is_1G), 64'd1);
        check("t2_2M",    64'(update_o.is_2M), 64'd0);
        check("t2_reads", 64'(rd_cnt - r0), 64'd1);
        @(negedge clk_i);
        u0 = upd_cnt; f0 = flt_cnt;
        start_walk(VA1, 1'b0);
        serve("t2b_l2", 56'h8000_0008, mk_pte(44'h40001, FL_ALL), 0);
        check("t2b_fault", 64'(fault_o), 64'd1);
        check("t2b_upd",   64'(update_o.valid), 64'd0);
        @(negedge clk_i);
        check("t2b_fcnt",  64'(flt_cnt - f0), 64'd1);
        check("t2b_ucnt",  64'(upd_cnt - u0), 64'd0);

        // Store to a clean page faults; a load to the same page refills
        u0 = upd_cnt;
        start_walk(VA3, 1'b1);
        serve("t3_l2", 56'h8000_0018, mk_pte(44'h40000, FL_ND), 0);
        check("t3_fault", 64'(fault_o), 64'd1);
        check("t3_fva",   fault_vaddr_o, VA3);
        @(negedge clk_i);
        check("t3_fpulse", 64'(fault_o), 64'd0);
        check("t3_fhold",  fault_vaddr_o, VA3);
        check("t3_ucnt",   64'(upd_cnt - u0), 64'd0);
        start_walk(VA3, 1'b0);
        serve("t3b_l2", 56'h8000_0018, mk_pte(44'h40000, FL_ND), 0);
        check("t3b_valid", 64'(update_o.valid), 64'd1);
        check("t3b_1G",    64'(update_o.is_1G), 64'd1);
        @(negedge clk_i);

        // Flush while waiting for read data: drain, no refill
        u0 = upd_cnt;
        start_walk(VA1, 1'b0);
        wait_req("t4");
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        flush_i   = 1'b1;
        @(negedge clk_i);
        flush_i   = 1'b0;
        check("t4_drain_walking", 64'(walking_o), 64'd1);
        repeat (4) @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mk_pte(44'h40000, FL_ALL);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("t4_upd",   64'(update_o.valid), 64'd0);
        check("t4_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        check("t4_ucnt",  64'(upd_cnt - u0), 64'd0);

        // Flush before grant drops the request
        start_walk(VA1, 1'b0);
        wait_req("t4b");
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("t4b_memreq", 64'(mem_req_o), 64'd0);
        check("t4b_ready",  64'(req_ready_o), 64'd1);

        // Non-canonical vaddr faults with no memory access
        @(negedge clk_i);
        req_seen = 1'b0;
        start_walk(VA_NC, 1'b0);
        check("t5_fault", 64'(fault_o), 64'd1);
        check("t5_fva",   fault_vaddr_o, VA_NC);
        @(negedge clk_i);
        check("t5_noreq", 64'(req_seen), 64'd0);
        check("t5_ready", 64'(req_ready_o), 64'd1);

        // Grant stalled 10 cycles, then a 2M leaf
        u0 = upd_cnt;
        start_walk(VA1, 1'b0);
        serve("t6_l2", 56'h8000_0008, mk_pte(44'h80001, FL_PTR), 10);
        serve("t6_l1", 56'h8000_1010, mk_pte(44'h80200, FL_ALL), 0);
        check("t6_valid", 64'(update_o.valid), 64'd1);
        check("t6_2M",    64'(update_o.is_2M), 64'd1);
        check("t6_1G",    64'(update_o.is_1G), 64'd0);
        check("t6_vpn",   64'(update_o.vpn), 64'h40403);
        @(negedge clk_i);
        check("t6_ucnt",  64'(upd_cnt - u0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
